// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, IF/ID register and RUN/FAULT control; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch_unit #(
  parameter int NUM_INSTR = 32,
  parameter int ADDR_W = $clog2(NUM_INSTR) * 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fetch_fault,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
);
  typedef enum logic {RUN, FAULT} state_t;
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(NUM_INSTR * 4);
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, out_pc_nx, fault_pc_nx;
  logic [31:0] out_instr_nx;
  logic out_valid_nx, advance, bad_target;
  assign imem_addr = pc;
  assign fetch_fault = (state == FAULT);
  assign advance = !out_valid || out_ready;
  assign bad_target = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MEM_BYTES);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
      fault_pc <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      out_valid <= out_valid_nx;
      out_instr <= out_instr_nx;
      out_pc <= out_pc_nx;
      fault_pc <= fault_pc_nx;
    end
  end
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    out_valid_nx = out_valid;
    out_instr_nx = out_instr;
    out_pc_nx = out_pc;
    fault_pc_nx = fault_pc;
    if (state == RUN) begin
      if (redirect_valid) begin
        out_valid_nx = 1'b0;
        state_nx = bad_target ? FAULT : RUN;
        fault_pc_nx = bad_target ? redirect_pc : fault_pc;
        pc_nx = bad_target ? pc : redirect_pc;
      end else if (advance && pc >= MEM_BYTES) begin
        state_nx = FAULT;
        fault_pc_nx = pc;
        out_valid_nx = 1'b0;
      end else if (advance) begin
        out_instr_nx = imem_instr;
        out_pc_nx = pc;
        out_valid_nx = 1'b1;
        pc_nx = pc + ADDR_W'(4);
      end
    end else begin
      out_valid_nx = 1'b0;
      if (redirect_valid) begin
        state_nx = bad_target ? FAULT : RUN;
        fault_pc_nx = bad_target ? redirect_pc : fault_pc;
        pc_nx = bad_target ? pc : redirect_pc;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (state == RUN) begin
      if (out_valid && out_ready) fetch_count <= fetch_count + 32'd1;
      if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a delivery scoreboard for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int AW = 20;
  logic clk = 0, rst = 1;
  logic [AW-1:0] imem_addr, redirect_pc = '0, out_pc, fault_pc;
  logic [31:0] imem_instr, out_instr, fetch_count, stall_count;
  logic redirect_valid = 0, out_valid, out_ready = 0, fetch_fault;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {logic [AW-1:0] pc; logic [31:0] instr;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault), .fault_pc(fault_pc),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    return (a < AW'(128)) ? 32'h00100013 + 32'(a >> 2) : 32'hdeadbeef;
  endfunction
  assign imem_instr = mem(imem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic push(input logic [AW-1:0] a);
    exp_q.push_back('{pc: a, instr: mem(a)});
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_pc"}, 32'(out_pc), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_fault"}, 32'(fetch_fault), 0);
    chk({tag, "_fault_pc"}, 32'(fault_pc), 0);
    chk({tag, "_fcnt"}, fetch_count, 0);
    chk({tag, "_scnt"}, stall_count, 0);
  endtask
  // Inputs are stable at the falling edge, so this sees exactly the handshakes the next rising edge completes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(out_pc), 32'hffffffff);
      else begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(out_pc), 32'(e.pc));
        chk("sb_instr", out_instr, e.instr);
      end
    end
  end
  initial begin
    step; step;
    chk_reset("reset");
    rst = 0; out_ready = 1;
    push(0); push(4);
    step;
    chk("first_valid", 32'(out_valid), 1);
    chk("first_pc", 32'(out_pc), 0);
    step;
    chk("second_pc", 32'(out_pc), 4);
    step;
    chk("third_pc", 32'(out_pc), 8);
    out_ready = 0;
    step; step; step;
    chk("stall_pc", 32'(out_pc), 8);
    chk("stall_instr", out_instr, mem(8));
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_addr", 32'(imem_addr), 12);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", stall_count, 3);
    chk("fetch_cnt", fetch_count, 2);
`else
    chk("stall_cnt", stall_count, 0);
    chk("fetch_cnt", fetch_count, 0);
`endif
    redirect_valid = 1; redirect_pc = AW'('h40);
    step;
    chk("flush_valid", 32'(out_valid), 0);
    redirect_valid = 0; out_ready = 1;
    push(AW'('h40));
    step;
    chk("redir_pc", 32'(out_pc), 'h40);
    chk("redir_instr", out_instr, mem(AW'('h40)));
    redirect_valid = 1; redirect_pc = AW'('h42);
    step;
    chk("bad_fault", 32'(fetch_fault), 1);
    chk("bad_fault_pc", 32'(fault_pc), 'h42);
    chk("bad_valid", 32'(out_valid), 0);
    chk("bad_addr", 32'(imem_addr), 'h44);
    redirect_valid = 0;
    step;
    chk("hold_fault", 32'(fetch_fault), 1);
    chk("hold_valid", 32'(out_valid), 0);
    redirect_valid = 1; redirect_pc = AW'('h10);
    step;
    chk("exit_fault", 32'(fetch_fault), 0);
    chk("exit_valid", 32'(out_valid), 0);
    chk("exit_addr", 32'(imem_addr), 'h10);
    redirect_valid = 0;
    push(AW'('h10));
    step;
    chk("exit_out_valid", 32'(out_valid), 1);
    chk("exit_out_pc", 32'(out_pc), 'h10);
    redirect_valid = 1; redirect_pc = AW'(124);
    step;
    chk("end_addr", 32'(imem_addr), 124);
    redirect_valid = 0;
    push(AW'(124));
    step;
    chk("end_pc", 32'(out_pc), 124);
    chk("end_instr", out_instr, mem(AW'(124)));
    step;
    chk("end_fault", 32'(fetch_fault), 1);
    chk("end_fault_pc", 32'(fault_pc), 128);
    chk("end_valid", 32'(out_valid), 0);
    rst = 1; redirect_valid = 1; redirect_pc = AW'('h20);
    step;
    chk_reset("rst_fault");
    rst = 0; redirect_valid = 0; out_ready = 0;
    step;
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
